// File: rtl/uart_tx_frame.sv
// FPGA->host configuration readback: sends sync, PAR_NUM parameter bytes and a checksum as 8N1 UART.
// Define UART_TX_PARITY_EN to insert an even parity bit after bit 7 of every byte.
module uart_tx_frame #(
  parameter int         CLK_MHZ      = 50,
  parameter int         BAUD         = 115200,
  parameter int         CONF_PAR_MAX = 8,
  parameter int         PAR_NUM      = 5,
  parameter int         ADDR_W       = 3,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_W-1:0]       par_addr,
  input  logic [CONF_PAR_MAX-1:0] par_data,
  output logic                    tx_out,
  output logic                    busy,
  output logic                    done
);

  localparam int BYTE_W = CONF_PAR_MAX;
  localparam int DIV    = (CLK_MHZ * 1000000) / BAUD;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
  localparam logic [3:0] PARITY_IDX = 4'd9;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam logic [3:0]        STOP_IDX  = 4'(BITS_PER_BYTE - 1);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(PAR_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PAR  = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [BYTE_W-1:0] d);
    return ^d;
  endfunction
`endif

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    baud_cnt_r;
  logic [3:0]          bit_cnt_r;
  logic [BYTE_W-1:0]   shift_r;
  logic [BYTE_W-1:0]   csum_r;
  logic [ADDR_W-1:0]   slot_r;
  logic [ADDR_W-1:0]   par_addr_r;
  logic                tx_out_r;
  logic                busy_r;
  logic                done_r;

  logic                active_s;
  logic                bit_end_s;
  logic                byte_end_s;
  logic                stop_first_s;
  logic                launch_s;
  logic                last_slot_s;
  logic                fetch_s;
  logic [ADDR_W-1:0]   fetch_idx_s;
  logic [2:0]          data_idx_s;
  logic                tx_s;
  logic                busy_s;
  logic                done_s;

  // Timing and fetch qualifiers derived from the current state and counters.
  always_comb begin
    active_s     = (state_r == ST_SYNC) || (state_r == ST_PAR) || (state_r == ST_CSUM);
    bit_end_s    = active_s && (baud_cnt_r == BAUD_LAST);
    byte_end_s   = bit_end_s && (bit_cnt_r == STOP_IDX);
    stop_first_s = active_s && (bit_cnt_r == STOP_IDX) && (baud_cnt_r == {CNT_W{1'b0}});
    // DONE doubles as the single idle-high clock, so a held start chains frames from there.
    launch_s     = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
    last_slot_s  = (slot_r == SLOT_LAST);
    data_idx_s   = 3'(bit_cnt_r - 4'd1);
    if (state_r == ST_SYNC) begin
      fetch_s     = 1'b1;
      fetch_idx_s = {ADDR_W{1'b0}};
    end else if ((state_r == ST_PAR) && !last_slot_s) begin
      fetch_s     = 1'b1;
      fetch_idx_s = slot_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_s     = 1'b0;
      fetch_idx_s = {ADDR_W{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SYNC;
        else       state_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (byte_end_s) state_s = ST_PAR;
        else            state_s = ST_SYNC;
      end
      ST_PAR: begin
        if (byte_end_s && last_slot_s) state_s = ST_CSUM;
        else                           state_s = ST_PAR;
      end
      ST_CSUM: begin
        if (byte_end_s) state_s = ST_DONE;
        else            state_s = ST_CSUM;
      end
      ST_DONE: begin
        if (start) state_s = ST_SYNC;
        else       state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Baud and bit counters; bytes follow each other with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= 4'd0;
    end else if (!active_s) begin
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= 4'd0;
    end else if (bit_end_s) begin
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= (bit_cnt_r == STOP_IDX) ? 4'd0 : bit_cnt_r + 4'd1;
    end else begin
      baud_cnt_r <= baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      bit_cnt_r  <= bit_cnt_r;
    end
  end

  // Byte shifter and checksum; parameters are captured at the end of the preceding stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {BYTE_W{1'b0}};
      csum_r  <= {BYTE_W{1'b0}};
      slot_r  <= {ADDR_W{1'b0}};
    end else if (launch_s) begin
      shift_r <= SYNC_BYTE;
      csum_r  <= {BYTE_W{1'b0}};
      slot_r  <= {ADDR_W{1'b0}};
    end else if (byte_end_s && fetch_s) begin
      shift_r <= par_data;
      csum_r  <= csum_r + par_data;
      slot_r  <= fetch_idx_s;
    end else if (byte_end_s && (state_r == ST_PAR)) begin
      shift_r <= csum_r;
      csum_r  <= csum_r;
      slot_r  <= slot_r;
    end else begin
      shift_r <= shift_r;
      csum_r  <= csum_r;
      slot_r  <= slot_r;
    end
  end

  // Parameter address: advanced on the first stop-bit clock, parked at 0 after the last capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_addr_r <= {ADDR_W{1'b0}};
    end else if (launch_s) begin
      par_addr_r <= {ADDR_W{1'b0}};
    end else if (stop_first_s && fetch_s) begin
      par_addr_r <= fetch_idx_s;
    end else if (byte_end_s && fetch_s && (fetch_idx_s == SLOT_LAST)) begin
      par_addr_r <= {ADDR_W{1'b0}};
    end else begin
      par_addr_r <= par_addr_r;
    end
  end

  // Output decode: line level for the current bit, busy and done flags.
  always_comb begin
    busy_s = active_s;
    done_s = (state_r == ST_DONE);
    if (!active_s) begin
      tx_s = 1'b1;
    end else if (bit_cnt_r == 4'd0) begin
      tx_s = 1'b0;
    end else if (bit_cnt_r <= 4'd8) begin
      tx_s = shift_r[data_idx_s];
`ifdef UART_TX_PARITY_EN
    end else if (bit_cnt_r == PARITY_IDX) begin
      tx_s = even_parity(shift_r);
`endif
    end else begin
      tx_s = 1'b1;
    end
  end

  // Output register; the asynchronous reset forces the line idle-high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      tx_out_r <= tx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign tx_out   = tx_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign par_addr = par_addr_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: line waveform and decoded bytes against a frame-level model.
module tb_uart_tx_frame;

  localparam int DIV     = 10;
  localparam int PAR_NUM = 5;
  localparam int ADDR_W  = 3;
`ifdef UART_TX_PARITY_EN
  localparam int BB = 11;
`else
  localparam int BB = 10;
`endif
  localparam int NB     = PAR_NUM + 2;
  localparam int FRAME  = NB * BB * DIV;
  localparam int MAXREC = 2400;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] par_addr;
  logic [7:0]        par_data;
  logic              tx_out;
  logic              busy;
  logic              done;

  logic [7:0] slots     [0:7];
  logic [7:0] exp_bytes [0:NB-1];
  logic       rec_tx    [0:MAXREC];
  logic       rec_busy  [0:MAXREC];
  logic       rec_done  [0:MAXREC];
  int vectors     = 0;
  int miscompares = 0;

  assign par_data = slots[par_addr];
  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_MHZ(1), .BAUD(100000), .CONF_PAR_MAX(8),
    .PAR_NUM(PAR_NUM), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .par_addr(par_addr),
    .par_data(par_data), .tx_out(tx_out), .busy(busy), .done(done)
  );

  // Reference frame: sync, slot values, sum mod 256.
  function automatic void build_expected();
    int sum;
    sum = 0;
    exp_bytes[0] = 8'hA5;
    for (int i = 0; i < PAR_NUM; i++) begin
      exp_bytes[i+1] = slots[i];
      sum += int'(slots[i]);
    end
    exp_bytes[NB-1] = 8'(sum % 256);
  endfunction

  // Expected line level t clocks into the frame.
  function automatic logic exp_line(input int t);
    int b;
    int bi;
    logic [7:0] v;
    b  = t / (BB * DIV);
    bi = (t / DIV) % BB;
    v  = exp_bytes[b];
    if (bi == 0) return 1'b0;
    if (bi <= 8) return v[bi-1];
    if ((BB == 11) && (bi == 9)) return ^v;
    return 1'b1;
  endfunction

  function automatic int wave_errs(input int base);
    int e;
    e = 0;
    for (int t = 0; t < FRAME; t++)
      if (rec_tx[base+1+t] !== exp_line(t)) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode_byte(input int base, input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[i] = rec_tx[base + 1 + b*BB*DIV + (1+i)*DIV + DIV/2];
    return v;
  endfunction

  function automatic int count_hi(input int which, input int lo, input int hi);
    int c;
    c = 0;
    for (int j = lo; j <= hi; j++) begin
      if ((which == 0) && (rec_tx[j] === 1'b1))   c++;
      if ((which == 1) && (rec_busy[j] === 1'b1)) c++;
      if ((which == 2) && (rec_done[j] === 1'b1)) c++;
    end
    return c;
  endfunction

  function automatic void set_slots(input logic [7:0] a, b, c, d, e);
    slots[0] = a; slots[1] = b; slots[2] = c; slots[3] = d; slots[4] = e;
  endfunction

  // Sample edge k takes start; rec[j] holds outputs 1 time unit after edge k+j.
  task automatic fire_and_record(input int n, input int hold, input int change_at,
                                 input logic [7:0] change_val, input int pulse_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (hold <= 1) start = 1'b0;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      rec_tx[j] = tx_out; rec_busy[j] = busy; rec_done[j] = done;
      if (j == change_at) slots[3] = change_val;
      if (j == pulse_at) start = 1'b1;
      else if (j >= hold - 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (tx_out !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (par_addr !== 3'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", par_addr); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] got;
    set_slots(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    build_expected();
    fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL single_wave: %0d bad clocks, want 0", wave_errs(0)); end
    for (int b = 0; b < NB; b++) begin
      got = decode_byte(0, b);
      vectors++; if (got !== exp_bytes[b]) begin miscompares++; $display("FAIL single_byte%0d: got %h want %h", b, got, exp_bytes[b]); end
    end
    got = decode_byte(0, NB-1);
    vectors++; if (got !== 8'h96) begin miscompares++; $display("FAIL single_csum: got %h want 96", got); end
    vectors++; if (count_hi(1, 1, FRAME+5) !== FRAME || rec_busy[1] !== 1'b1 || rec_busy[FRAME+1] !== 1'b0) begin
      miscompares++; $display("FAIL single_busy: %0d busy clocks want %0d", count_hi(1, 1, FRAME+5), FRAME); end
    vectors++; if (count_hi(2, 1, FRAME+5) !== 1 || rec_done[FRAME+1] !== 1'b1) begin
      miscompares++; $display("FAIL single_done: %0d pulses, at_expected=%b want 1 and 1", count_hi(2, 1, FRAME+5), rec_done[FRAME+1]); end
    vectors++; if (count_hi(0, FRAME+1, FRAME+5) !== 5) begin
      miscompares++; $display("FAIL single_idle: %0d high clocks want 5", count_hi(0, FRAME+1, FRAME+5)); end
    vectors++; if (par_addr !== 3'd0) begin miscompares++; $display("FAIL single_addr_park: got %0d want 0", par_addr); end
  endtask

  task automatic test_all_ff();
    logic [7:0] got;
    set_slots(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    build_expected();
    fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL ff_wave: %0d bad clocks, want 0", wave_errs(0)); end
    got = decode_byte(0, NB-1);
    vectors++; if (got !== 8'hFB) begin miscompares++; $display("FAIL ff_csum: got %h want FB", got); end
  endtask

  task automatic test_start_held();
    int waited;
    set_slots(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    build_expected();
    fire_and_record(2000, 2000, 0, 8'h00, 0);
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL held_wave1: %0d bad clocks, want 0", wave_errs(0)); end
    vectors++; if (rec_tx[FRAME+1] !== 1'b1 || rec_done[FRAME+1] !== 1'b1) begin
      miscompares++; $display("FAIL held_gap1: tx=%b done=%b want 1 1", rec_tx[FRAME+1], rec_done[FRAME+1]); end
    vectors++; if (wave_errs(FRAME+1) !== 0) begin miscompares++; $display("FAIL held_wave2: %0d bad clocks, want 0", wave_errs(FRAME+1)); end
    vectors++; if (rec_tx[2*FRAME+2] !== 1'b1 || rec_done[2*FRAME+2] !== 1'b1) begin
      miscompares++; $display("FAIL held_gap2: tx=%b done=%b want 1 1", rec_tx[2*FRAME+2], rec_done[2*FRAME+2]); end
    vectors++; if (rec_tx[2*FRAME+3] !== 1'b0 || rec_busy[2*FRAME+3] !== 1'b1) begin
      miscompares++; $display("FAIL held_third: tx=%b busy=%b want 0 1", rec_tx[2*FRAME+3], rec_busy[2*FRAME+3]); end
    waited = 0;
    while (done !== 1'b1 && waited < 1500) begin
      @(posedge clk); #1; waited++;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL held_third_done: timeout after %0d clocks, want done", waited); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_start_ignored();
    set_slots(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    build_expected();
    fire_and_record(FRAME + 100, 1, 0, 8'h00, 300);
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL ignore_wave: %0d bad clocks, want 0", wave_errs(0)); end
    vectors++; if (count_hi(0, FRAME+1, FRAME+100) !== 100 || count_hi(2, 1, FRAME+100) !== 1) begin
      miscompares++; $display("FAIL ignore_no_queue: high=%0d done=%0d want 100 1", count_hi(0, FRAME+1, FRAME+100), count_hi(2, 1, FRAME+100)); end
  endtask

  task automatic test_midframe_change();
    logic [7:0] got;
    set_slots(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    build_expected();
    fire_and_record(FRAME + 5, 1, 4*BB*DIV + 50, 8'd99, 0);
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL change_wave1: %0d bad clocks, want 0", wave_errs(0)); end
    got = decode_byte(0, 4);
    vectors++; if (got !== 8'h28) begin miscompares++; $display("FAIL change_slot3_old: got %h want 28", got); end
    got = decode_byte(0, NB-1);
    vectors++; if (got !== 8'h96) begin miscompares++; $display("FAIL change_csum_old: got %h want 96", got); end
    build_expected();
    fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
    got = decode_byte(0, 4);
    vectors++; if (got !== 8'h63) begin miscompares++; $display("FAIL change_slot3_new: got %h want 63", got); end
    got = decode_byte(0, NB-1);
    vectors++; if (got !== 8'hD1) begin miscompares++; $display("FAIL change_csum_new: got %h want D1", got); end
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL change_wave2: %0d bad clocks, want 0", wave_errs(0)); end
  endtask

  task automatic test_reset_midframe();
    int t;
    int n_done;
    int n_busy;
    int n_low;
    set_slots(8'd10, 8'd20, 8'hEE, 8'd40, 8'd50);
    t = 3*BB*DIV + 5*DIV + DIV/2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (t + 1) @(posedge clk);
    #3;
    vectors++; if (tx_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre: tx=%b want 0 (bit 4 of 0xEE)", tx_out); end
    rst = 1'b1;
    #1;
    vectors++; if (tx_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_async: got %b want 1", tx_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_done = 0; n_busy = 0; n_low = 0;
    for (int j = 0; j < FRAME + 50; j++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
      if (tx_out !== 1'b1) n_low++;
    end
    vectors++; if (n_done !== 0 || n_busy !== 0 || n_low !== 0) begin
      miscompares++; $display("FAIL rstmid_quiet: done=%0d busy=%0d low=%0d want 0 0 0", n_done, n_busy, n_low); end
    set_slots(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    build_expected();
    fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
    vectors++; if (wave_errs(0) !== 0 || rec_done[FRAME+1] !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_recover: %0d bad clocks done=%b want 0 1", wave_errs(0), rec_done[FRAME+1]); end
  endtask

  task automatic test_random();
    logic [7:0] got;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < PAR_NUM; i++) slots[i] = 8'($urandom_range(0, 255));
      build_expected();
      fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
      vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL rand%0d_wave: %0d bad clocks, want 0", r, wave_errs(0)); end
      got = decode_byte(0, NB-1);
      vectors++; if (got !== exp_bytes[NB-1]) begin miscompares++; $display("FAIL rand%0d_csum: got %h want %h", r, got, exp_bytes[NB-1]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic par_exp [0:6];
    logic got;
    par_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    set_slots(8'h01, 8'h03, 8'h00, 8'h80, 8'h7F);
    build_expected();
    fire_and_record(FRAME + 5, 1, 0, 8'h00, 0);
    for (int b = 0; b < 7; b++) begin
      got = rec_tx[1 + b*BB*DIV + 9*DIV + DIV/2];
      vectors++; if (got !== par_exp[b]) begin miscompares++; $display("FAIL parity_byte%0d: got %b want %b", b, got, par_exp[b]); end
    end
    vectors++; if (count_hi(1, 1, FRAME+5) !== 770 || rec_done[771] !== 1'b1) begin
      miscompares++; $display("FAIL parity_len: busy=%0d done771=%b want 770 1", count_hi(1, 1, FRAME+5), rec_done[771]); end
    vectors++; if (wave_errs(0) !== 0) begin miscompares++; $display("FAIL parity_wave: %0d bad clocks, want 0", wave_errs(0)); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) slots[i] = 8'h00;
    test_reset();
    test_single_frame();
    test_all_ff();
    test_start_held();
    test_start_ignored();
    test_midframe_change();
    test_reset_midframe();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
